// File: rtl/code_display_scan_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment scanner:
// scan state encoding, active-low segment patterns and digit enables.
package code_display_scan_pkg;

    typedef enum logic [1:0] {
        ST_DIG0   = 2'd0,
        ST_BLANK0 = 2'd1,
        ST_DIG1   = 2'd2,
        ST_BLANK1 = 2'd3
    } scan_state_t;

    // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Digit enables, active-low
    localparam logic [1:0] AN_DIG0 = 2'b10;
    localparam logic [1:0] AN_DIG1 = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    // True when the nibble is a displayable decimal digit
    function automatic logic is_decimal(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/code_display_scan_seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder.
// Codes above 9 show a dash and raise err.
module seg7_decode
    import code_display_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg,
    output logic       err
);

    // Pattern lookup; anything outside 0..9 falls to the dash
    always_comb begin
        seg = SEG_DASH;
        err = !is_decimal(code);
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/code_display_scan.sv
// Two-digit time-multiplexed display scanner for the code converter.
//
// state  | meaning
// -------+------------------------------------------------
// DIG0   | digit0 lit with hold1 (code1 snapshot)
// BLANK0 | all digits off, separates digit0 from digit1
// DIG1   | digit1 lit with hold2 (code2 snapshot)
// BLANK1 | all digits off; both inputs sampled on exit
//
// Both nibbles are captured together on the BLANK1->DIG0 edge so the two
// digits of one frame always belong to the same input snapshot.
module code_display_scan
    import code_display_scan_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code1,
    input  logic [3:0] code2,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       err,
    output logic       frame_done
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [3:0]       hold1;
    logic [3:0]       hold2;
    logic [3:0]       dec_code;
    logic [6:0]       dec_seg;
    logic             dec_err;

    assign tick = (cnt == CNT_MAX);

    // Slot prescaler: one tick per SCAN_DIV clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Scan state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DIG0;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed ring of slots, advancing once per tick
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_DIG0:   state_d = ST_BLANK0;
                ST_BLANK0: state_d = ST_DIG1;
                ST_DIG1:   state_d = ST_BLANK1;
                ST_BLANK1: state_d = ST_DIG0;
                default:   state_d = ST_DIG0;
            endcase
        end
    end

    // Frame snapshot of both nibbles plus the new-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold1      <= '0;
            hold2      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && (state_q == ST_BLANK1);
            if (tick && (state_q == ST_BLANK1)) begin
                hold1 <= code1;
                hold2 <= code2;
            end
        end
    end

    // A single decoder serves both digits; feed it the nibble of the lit digit
    always_comb begin
        dec_code = hold1;
        if (state_q == ST_DIG1) begin
            dec_code = hold2;
        end
    end

    seg7_decode u_decode (
        .code (dec_code),
        .seg  (dec_seg),
        .err  (dec_err)
    );

    // Drive the display from registered state only; blanks force all off
    always_comb begin
        an  = AN_OFF;
        seg = SEG_OFF;
        err = 1'b0;
        case (state_q)
            ST_DIG0: begin
                an  = AN_DIG0;
                seg = dec_seg;
                err = dec_err;
            end
            ST_DIG1: begin
                an  = AN_DIG1;
                seg = dec_seg;
                err = dec_err;
            end
            default: begin
                an  = AN_OFF;
                seg = SEG_OFF;
                err = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_code_display_scan.sv
// Self-checking bench: two scanners (SCAN_DIV = 4 and 2) share inputs and
// are compared against a slot-arithmetic model through a scoreboard queue.
module tb_code_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code1 = 4'd0;
    logic [3:0] code2 = 4'd0;

    logic [1:0] an4, an2;
    logic [6:0] seg4, seg2;
    logic       err4, err2;
    logic       fd4, fd2;

    always #5 clk = ~clk;

    code_display_scan #(.SCAN_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .code1(code1), .code2(code2),
        .an(an4), .seg(seg4), .err(err4), .frame_done(fd4)
    );

    code_display_scan #(.SCAN_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .code1(code1), .code2(code2),
        .an(an2), .seg(seg2), .err(err2), .frame_done(fd2)
    );

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
        logic       err;
    } dec_vec_t;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       err;
        logic       fd;
    } exp_t;

    typedef struct packed {
        exp_t e4;
        exp_t e2;
    } pair_t;

    dec_vec_t   tbl [16];
    pair_t      sbq [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         m_cyc = 0;
    logic [3:0] m4h1 = 4'd0, m4h2 = 4'd0, m2h1 = 4'd0, m2h2 = 4'd0;

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, want);
        end
    endtask

    // Expected display for a scanner with slot length s, cycle cyc since reset
    function automatic exp_t model(input int s, input int cyc, input logic [3:0] h1, input logic [3:0] h2);
        exp_t e;
        int   slot;
        slot  = (cyc / s) % 4;
        e.an  = 2'b11;
        e.seg = 7'h7F;
        e.err = 1'b0;
        e.fd  = (cyc > 0) && ((cyc % (4 * s)) == 0);
        if (slot == 0) begin
            e.an  = 2'b10;
            e.seg = tbl[h1].seg;
            e.err = tbl[h1].err;
        end else if (slot == 2) begin
            e.an  = 2'b01;
            e.seg = tbl[h2].seg;
            e.err = tbl[h2].err;
        end
        return e;
    endfunction

    task automatic push_exp();
        pair_t p;
        p.e4 = model(4, m_cyc, m4h1, m4h2);
        p.e2 = model(2, m_cyc, m2h1, m2h2);
        sbq.push_back(p);
    endtask

    task automatic check_now();
        pair_t p;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", m_cyc, 8'd1, 8'd0);
        end else begin
            p = sbq.pop_front();
            chk("an_div4",  m_cyc, {6'd0, an4},  {6'd0, p.e4.an});
            chk("seg_div4", m_cyc, {1'b0, seg4}, {1'b0, p.e4.seg});
            chk("err_div4", m_cyc, {7'd0, err4}, {7'd0, p.e4.err});
            chk("fd_div4",  m_cyc, {7'd0, fd4},  {7'd0, p.e4.fd});
            chk("an_div2",  m_cyc, {6'd0, an2},  {6'd0, p.e2.an});
            chk("seg_div2", m_cyc, {1'b0, seg2}, {1'b0, p.e2.seg});
            chk("err_div2", m_cyc, {7'd0, err2}, {7'd0, p.e2.err});
            chk("fd_div2",  m_cyc, {7'd0, fd2},  {7'd0, p.e2.fd});
        end
    endtask

    // Drive inputs for the current cycle, then observe the next one
    task automatic advance(input logic [3:0] c1, input logic [3:0] c2);
        code1 = c1;
        code2 = c2;
        m_cyc++;
        if ((m_cyc % 16) == 0) begin
            m4h1 = c1;
            m4h2 = c2;
        end
        if ((m_cyc % 8) == 0) begin
            m2h1 = c1;
            m2h2 = c2;
        end
        push_exp();
        @(negedge clk);
        check_now();
    endtask

    // Model back to the post-reset cycle 0, checked immediately
    task automatic restart();
        m_cyc = 0;
        m4h1 = 4'd0; m4h2 = 4'd0;
        m2h1 = 4'd0; m2h2 = 4'd0;
        sbq.delete();
        push_exp();
        check_now();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an4"},  -1, {6'd0, an4},  8'h02);
        chk({tag, "_seg4"}, -1, {1'b0, seg4}, 8'h40);
        chk({tag, "_err4"}, -1, {7'd0, err4}, 8'h00);
        chk({tag, "_fd4"},  -1, {7'd0, fd4},  8'h00);
        chk({tag, "_an2"},  -1, {6'd0, an2},  8'h02);
        chk({tag, "_seg2"}, -1, {1'b0, seg2}, 8'h40);
        chk({tag, "_fd2"},  -1, {7'd0, fd2},  8'h00);
    endtask

    initial begin
        tbl[0]  = '{4'd0,  7'h40, 1'b0};
        tbl[1]  = '{4'd1,  7'h79, 1'b0};
        tbl[2]  = '{4'd2,  7'h24, 1'b0};
        tbl[3]  = '{4'd3,  7'h30, 1'b0};
        tbl[4]  = '{4'd4,  7'h19, 1'b0};
        tbl[5]  = '{4'd5,  7'h12, 1'b0};
        tbl[6]  = '{4'd6,  7'h02, 1'b0};
        tbl[7]  = '{4'd7,  7'h78, 1'b0};
        tbl[8]  = '{4'd8,  7'h00, 1'b0};
        tbl[9]  = '{4'd9,  7'h10, 1'b0};
        tbl[10] = '{4'd10, 7'h3F, 1'b1};
        tbl[11] = '{4'd11, 7'h3F, 1'b1};
        tbl[12] = '{4'd12, 7'h3F, 1'b1};
        tbl[13] = '{4'd13, 7'h3F, 1'b1};
        tbl[14] = '{4'd14, 7'h3F, 1'b1};
        tbl[15] = '{4'd15, 7'h3F, 1'b1};

        // Reset held: outputs show DIG0 of an all-zero snapshot
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_held");

        // Snapshot timing, mid-frame change and invalid code on digit1
        code1 = 4'd3;
        code2 = 4'd8;
        rst   = 1'b0;
        #1;
        restart();
        for (int c = 0; c < 48; c++) begin
            advance((c >= 18) ? 4'd5 : 4'd3, (c >= 20) ? 4'd12 : 4'd8);
        end

        // Every code on digit0, its complement index on digit1, a frame each
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) begin
                advance(tbl[i].code, tbl[15 - i].code);
            end
        end
        for (int k = 0; k < 20; k++) begin
            advance(4'd7, 4'd9);
        end

        // Async reset in the middle of a DIG1 slot
        for (int k = 0; k < 16 && (m_cyc % 16) != 9; k++) begin
            advance(4'd7, 4'd9);
        end
        chk("reached_dig1", m_cyc, {6'd0, an4}, 8'h01);
        rst = 1'b1;
        #1;
        chk_reset_outputs("reset_async");
        #1;
        rst = 1'b0;
        #1;
        restart();
        for (int k = 0; k < 40; k++) begin
            advance(4'd7, 4'd9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/code_display_scan.md
Name: code_display_scan

Overview:
Downstream consumer of the 4-bit code converter. Takes the converter's two 4-bit result nibbles and drives a 2-digit, time-multiplexed, active-low 7-segment display: one digit at a time, with a blanking slot between digits to prevent ghosting. Both nibbles are sampled together once per frame so the two digits always show the same input snapshot.

Parameters:
SCAN_DIV, 4, clocks per scan slot; legal range ≥ 2. Use 4 in simulation; set it large (e.g. 100000) on the board.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
code1  input  4  first converter result {a1,b1,c1,d1}; a1 is the MSB.
code2  input  4  second converter result {a2,b2,c2,d2}; a2 is the MSB.
an  output  2  digit enables, active-low. an[0] selects digit0 (code1), an[1] selects digit1 (code2).
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
err  output  1  high while the digit currently lit holds a code greater than 9.
frame_done  output  1  one-cycle pulse marking a new snapshot.

Behaviour:
- Prescaler
  - cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (cnt == SCAN_DIV-1).
  - Each state lasts exactly SCAN_DIV cycles; a full frame is 4*SCAN_DIV cycles.
- State sequence: DIG0 -> BLANK0 -> DIG1 -> BLANK1 -> DIG0.
  - The state advances on the clock edge where tick = 1.
  - No other transitions exist.
- Snapshot
  - On the BLANK1->DIG0 edge, hold1 <= code1 and hold2 <= code2.
  - Input changes at any other time are invisible until the next frame.
- frame_done
  - Registered; high for the first cycle of DIG0 after a BLANK1->DIG0 edge.
  - Not asserted after reset.
- Outputs
  - Decoded only from registered state and hold registers; there is no combinational path from inputs to outputs.
  - DIG0: an = 2'b10, seg = decode(hold1).
  - DIG1: an = 2'b01, seg = decode(hold2).
  - BLANK0 / BLANK1: an = 2'b11, seg = 7'h7F, err = 0.
- Decode (hex, active-low gfedcba):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Codes 10..15 = 3F (dash). err = 1 only while a 10..15 digit is lit.
- Reset (async, any time, including mid-frame)
  - Immediately: state = DIG0, cnt = 0, hold1 = hold2 = 0, frame_done = 0.
  - Therefore an = 2'b10, seg = 7'h40, err = 0.
  - After reset deasserts, DIG0 runs a full SCAN_DIV cycles.
- Width rule: cnt width = $clog2(SCAN_DIV).

Decomposition:
- Shared package: state encoding (DIG0 = 0, BLANK0 = 1, DIG1 = 2, BLANK1 = 3), the segment constants SEG_0..SEG_9, SEG_DASH = 7'h3F, SEG_OFF = 7'h7F, and the AN_* enable constants.
- One natural sub-module: seg7_decode, combinational 4-bit -> {seg[6:0], err}. It is instantiated once, fed by a state-selected hold register.

Test Plan:
All scenarios use SCAN_DIV = 4; cycle 0 is the first edge after rst falls.
- Reset value: assert rst -> an = 2'b10, seg = 7'h40, err = 0, frame_done = 0 during reset and through cycles 0–3.
- Snapshot timing: code1 = 3, code2 = 8 held from cycle 0 ->
  - cycles 4–7: an = 11, seg = 7F.
  - cycles 8–11: an = 01, seg = 40 (old snapshot).
  - cycle 16: frame_done = 1; cycles 16–19: an = 10, seg = 30.
  - cycles 24–27: an = 01, seg = 00.
- Mid-frame change: code1 changes 3 -> 5 at cycle 18 -> DIG0 at cycles 16–19 stays seg = 30; DIG0 at cycles 32–35 shows seg = 12.
- Invalid code: code2 = 12 -> in the next frame's DIG1 slot seg = 3F, err = 1; err = 0 in DIG0 (code1 valid) and in both blank slots.
- Async reset mid-DIG1: pulse rst between edges at cycle 9 -> same timestep an = 10, seg = 40; after release, DIG0 lasts 4 cycles and hold1 = hold2 = 0.
- Period check: SCAN_DIV = 2 -> frame_done pulses every 8 cycles; each an pattern lasts exactly 2 cycles.
